mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle successor to the single-cycle MIPS controller. Drives a shared-memory, multicycle datapath with one FSM that sequences fetch, decode, execute, memory and writeback.
- Adds three things:
  - a variable-latency memory handshake (mem_ready wait states);
  - illegal-opcode detection;
  - a retired-instruction counter.
- Sits beside the multicycle data_path inside the processor top.

Parameters:
- ALU_CTRL_W, 3: alu_cntrl width. Must be ≥3; bits above [2:0] are driven 0.
- CNT_W, 32: retired-instruction counter width.
- WAIT_EN, 1: 1 means honour mem_ready; 0 means mem_ready is treated as constant 1 (zero-wait memory).

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Asynchronous, active-high reset.
- opcode  input  6  IR[31:26]; sampled in DECODE and later states.
- func  input  6  IR[5:0].
- ZERO  input  1  ALU zero flag.
- mem_ready  input  1  Memory access completes in this cycle.
- pc_write  output  1  PC load enable; already qualified by ZERO for beq.
- i_or_d  output  1  0 = address from PC, 1 = address from ALUOut.
- mem_read  output  1  Memory read request.
- mem_write  output  1  Memory write request.
- ir_write  output  1  IR load enable.
- mdr_write  output  1  MDR load enable.
- reg_dst  output  2  Write-register select: 0 rt, 1 rd, 2 $31.
- mem_to_reg  output  2  Write-data select: 0 ALUOut, 1 MDR, 2 PC.
- reg_write  output  1  Register-file write enable.
- alu_src_a  output  1  ALU A select: 0 PC, 1 A.
- alu_src_b  output  2  ALU B select: 0 B, 1 const 4, 2 sign-extended immediate, 3 sign-extended immediate << 2.
- alu_cntrl  output  ALU_CTRL_W  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_src  output  2  Next-PC select: 0 ALU result, 1 ALUOut, 2 jump target, 3 A (jr).
- illegal  output  1  One-cycle pulse on an undecodable instruction.
- instr_count  output  CNT_W  Number of retired instructions.
- state  output  4  Current FSM state, for debug.

Behaviour:
- Reset (asynchronous):
  - While rst is high, state = FETCH, instr_count = 0, and every control output is forced to 0.
  - After rst falls, the first rising edge finds the FSM in FETCH.
  - Asserting rst mid-instruction abandons it; no partial writes are issued after rst rises.
- Outputs are decoded from state. pc_write and ir_write additionally depend on mem_ready or ZERO, as listed below. Any output not listed for a state is 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_cntrl=add, pc_src=0.
  - Stays in FETCH while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, alu_cntrl=add (precomputes the branch target).
  - Next state by opcode:
    - 000000 with func in {100000, 100010, 100100, 100101, 101010} → R_EXEC.
    - 000000 with func 001000 → JR.
    - 100011 / 101011 → MEM_ADDR.
    - 001000 / 001010 / 001100 / 001101 (addi, slti, andi, ori) → I_EXEC.
    - 000100 → BRANCH.
    - 000010 → JUMP.
    - 000011 → JAL.
    - anything else → ILLEGAL.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_cntrl from func (add, sub, and, or, slt). Next state R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1; the instruction retires. Next state FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2, alu_cntrl = add / slt / and / or by opcode. Next state I_WB.
- I_WB: reg_dst=0, mem_to_reg=0, reg_write=1; retires. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, add. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD:
  - Drives i_or_d=1, mem_read=1.
  - Waits while mem_ready=0.
  - When mem_ready=1: mdr_write=1, next state MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1; retires. Next state FETCH.
- MEM_WR:
  - Drives i_or_d=1, mem_write=1.
  - Waits while mem_ready=0.
  - When mem_ready=1: retires, next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_src=1, pc_write=ZERO; retires whether or not the branch is taken. Next state FETCH.
- JUMP: pc_src=2, pc_write=1; retires. Next state FETCH.
- JAL: pc_src=2, pc_write=1, reg_dst=2, mem_to_reg=2, reg_write=1 (writes the old PC+4); retires. Next state FETCH.
- JR: pc_src=3, pc_write=1; retires. Next state FETCH.
- ILLEGAL: illegal=1 for exactly one cycle; no register or PC write; not counted as retired. Next state FETCH.
- Latency with zero-wait memory:
  - beq, j, jal, jr: 3 cycles.
  - R-type, I-type, sw: 4 cycles.
  - lw: 5 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- instr_count increments by 1 on the clock edge that leaves each retiring state. It wraps from 2^CNT_W−1 to 0.
- When mem_ready is high in a state that makes no memory request, it is ignored.

Test Plan:
- Reset pulse mid-R_EXEC → state = FETCH (0), all outputs 0, instr_count = 0 while rst is high; mem_read=1 on the first cycle after release.
- add (opcode 0, func 100000) with mem_ready tied to 1 → state sequence FETCH, DECODE, R_EXEC, R_WB; alu_cntrl=010 in R_EXEC; reg_write=1, reg_dst=1 in R_WB; instr_count 0→1.
- lw (100011) with mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEM_RD → 10 cycles total; ir_write and mdr_write each pulse exactly once, each coinciding with mem_ready=1.
- beq with ZERO=0, then again with ZERO=1 → pc_write=0 then pc_write=1 in BRANCH, pc_src=1; instr_count +2.
- jal (000011) → reg_dst=2, mem_to_reg=2, reg_write=1, pc_write=1, pc_src=2 in the same cycle; 3 cycles total.
- opcode 111111 → illegal=1 for one cycle, no reg_write or pc_write outside FETCH, instr_count unchanged; with CNT_W=4, retiring 17 instructions gives instr_count = 1.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM. Sequences fetch, decode,
// execute, memory and writeback over a shared-memory datapath, stalls on
// mem_ready, flags undecodable instructions and counts retirements.
module mc_controller #(
    parameter int ALU_CTRL_W = 3,
    parameter int CNT_W      = 32,
    parameter bit WAIT_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            func,
    input  logic                  ZERO,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  i_or_d,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  mdr_write,
    output logic [1:0]            reg_dst,
    output logic [1:0]            mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_cntrl,
    output logic [1:0]            pc_src,
    output logic                  illegal,
    output logic [CNT_W-1:0]      instr_count,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        I_EXEC   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        JAL      = 4'd12,
        JR       = 4'd13,
        ILLEGAL  = 4'd14
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q;
    state_t     dec_next;
    logic       mem_ok;
    logic       retire;
    logic [2:0] alu3;

    // Zero-wait builds ignore the handshake entirely.
    assign mem_ok    = WAIT_EN ? mem_ready : 1'b1;
    assign state     = state_q;
    assign alu_cntrl = ALU_CTRL_W'(alu3);

    // Instruction decode: pick the execute state from opcode/func.
    always_comb begin
        dec_next = ILLEGAL;
        case (opcode)
            6'b000000: begin
                case (func)
                    6'b100000, 6'b100010, 6'b100100,
                    6'b100101, 6'b101010: dec_next = R_EXEC;
                    6'b001000:            dec_next = JR;
                    default:              dec_next = ILLEGAL;
                endcase
            end
            6'b100011, 6'b101011:                       dec_next = MEM_ADDR;
            6'b001000, 6'b001010, 6'b001100, 6'b001101: dec_next = I_EXEC;
            6'b000100:                                  dec_next = BRANCH;
            6'b000010:                                  dec_next = JUMP;
            6'b000011:                                  dec_next = JAL;
            default:                                    dec_next = ILLEGAL;
        endcase
    end

    // Retiring states; a store retires only once memory accepts it.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            R_WB, I_WB, MEM_WB, BRANCH, JUMP, JAL, JR: retire = 1'b1;
            MEM_WR:                                    retire = mem_ok;
            default:                                   retire = 1'b0;
        endcase
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            instr_count <= '0;
        end else begin
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
            case (state_q)
                FETCH:    if (mem_ok) state_q <= DECODE;
                DECODE:   state_q <= dec_next;
                MEM_ADDR: state_q <= opcode[3] ? MEM_WR : MEM_RD;
                MEM_RD:   if (mem_ok) state_q <= MEM_WB;
                MEM_WR:   if (mem_ok) state_q <= FETCH;
                R_EXEC:   state_q <= R_WB;
                I_EXEC:   state_q <= I_WB;
                default:  state_q <= FETCH;
            endcase
        end
    end

    // Control outputs decoded from state; all held low while in reset.
    always_comb begin
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu3       = 3'b000;
        pc_src     = 2'd0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;
                    alu3      = ALU_ADD;
                    ir_write  = mem_ok;
                    pc_write  = mem_ok;
                end
                DECODE: begin
                    alu_src_b = 2'd3;
                    alu3      = ALU_ADD;
                end
                R_EXEC: begin
                    alu_src_a = 1'b1;
                    case (func)
                        6'b100010: alu3 = ALU_SUB;
                        6'b100100: alu3 = ALU_AND;
                        6'b100101: alu3 = ALU_OR;
                        6'b101010: alu3 = ALU_SLT;
                        default:   alu3 = ALU_ADD;
                    endcase
                end
                R_WB: begin
                    reg_dst   = 2'd1;
                    reg_write = 1'b1;
                end
                I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    case (opcode)
                        6'b001010: alu3 = ALU_SLT;
                        6'b001100: alu3 = ALU_AND;
                        6'b001101: alu3 = ALU_OR;
                        default:   alu3 = ALU_ADD;
                    endcase
                end
                I_WB: reg_write = 1'b1;
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    alu3      = ALU_ADD;
                end
                MEM_RD: begin
                    i_or_d    = 1'b1;
                    mem_read  = 1'b1;
                    mdr_write = mem_ok;
                end
                MEM_WB: begin
                    mem_to_reg = 2'd1;
                    reg_write  = 1'b1;
                end
                MEM_WR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu3      = ALU_SUB;
                    pc_src    = 2'd1;
                    pc_write  = ZERO;
                end
                JUMP: begin
                    pc_src   = 2'd2;
                    pc_write = 1'b1;
                end
                JAL: begin
                    pc_src     = 2'd2;
                    pc_write   = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                    reg_write  = 1'b1;
                end
                JR: begin
                    pc_src   = 2'd3;
                    pc_write = 1'b1;
                end
                ILLEGAL: illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed-vector bench for mc_controller (CNT_W=4 so the
// counter wrap is reachable, ALU_CTRL_W=4 so the zero upper bit is visible).
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, func;
    logic       ZERO, mem_ready;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, mdr_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic       reg_write, alu_src_a, illegal;
    logic [3:0] alu_cntrl;
    logic [3:0] instr_count;
    logic [3:0] state;
    logic [20:0] ctl;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [3:0] S_FETCH = 4'd0, S_DEC = 4'd1, S_MA = 4'd2, S_MRD = 4'd3,
        S_MWB = 4'd4, S_MWR = 4'd5, S_REX = 4'd6, S_RWB = 4'd7, S_IEX = 4'd8,
        S_IWB = 4'd9, S_BR = 4'd10, S_J = 4'd11, S_JAL = 4'd12, S_JR = 4'd13, S_ILL = 4'd14;
    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND_ = 4'b0000, OR_ = 4'b0001, SLT = 4'b0111;

    always #5 clk = ~clk;

    mc_controller #(.ALU_CTRL_W(4), .CNT_W(4), .WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .ZERO(ZERO),
        .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mdr_write(mdr_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_cntrl(alu_cntrl), .pc_src(pc_src), .illegal(illegal),
        .instr_count(instr_count), .state(state)
    );

    assign ctl = {pc_write, i_or_d, mem_read, mem_write, ir_write, mdr_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_cntrl, pc_src, illegal};

    function automatic logic [20:0] cv(logic pcw, iord, mr, mw, irw, mdrw,
                                       logic [1:0] rd, mtr, logic rw, asa,
                                       logic [1:0] asb, logic [3:0] alu,
                                       logic [1:0] pcs, logic ill);
        return {pcw, iord, mr, mw, irw, mdrw, rd, mtr, rw, asa, asb, alu, pcs, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, let decode settle, check, advance past the edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic mr, input logic [3:0] es,
                        input logic [20:0] ec);
        opcode = op; func = fn; ZERO = z; mem_ready = mr;
        #1;
        chk({tag, ".state"}, 32'(state), 32'(es));
        chk({tag, ".ctl"}, 32'(ctl), 32'(ec));
        @(posedge clk); #1;
    endtask

    logic [20:0] F_RDY, F_WAIT, DEC, C_RWB, C_IEX_ADD;

    initial begin
        F_RDY  = cv(1,0,1,0,1,0,0,0,0,0,1,ADD,0,0);
        F_WAIT = cv(0,0,1,0,0,0,0,0,0,0,1,ADD,0,0);
        DEC    = cv(0,0,0,0,0,0,0,0,0,0,3,ADD,0,0);
        C_RWB  = cv(0,0,0,0,0,0,1,0,1,0,0,4'd0,0,0);
        C_IEX_ADD = cv(0,0,0,0,0,0,0,0,0,1,2,ADD,0,0);

        // Reset with mem_ready high: everything forced low.
        rst = 1'b1; opcode = '0; func = '0; ZERO = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.state", 32'(state), 32'(S_FETCH));
        chk("rst.ctl", 32'(ctl), 32'd0);
        chk("rst.cnt", 32'(instr_count), 32'd0);
        rst = 1'b0;

        // add, zero-wait
        step("add.f", 6'h00, 6'b100000, 0, 1, S_FETCH, F_RDY);
        step("add.d", 6'h00, 6'b100000, 0, 1, S_DEC, DEC);
        step("add.x", 6'h00, 6'b100000, 0, 1, S_REX, cv(0,0,0,0,0,0,0,0,0,1,0,ADD,0,0));
        step("add.w", 6'h00, 6'b100000, 0, 1, S_RWB, C_RWB);
        chk("add.cnt", 32'(instr_count), 32'd1);

        // lw with 2 fetch waits and 3 read waits: 10 cycles
        step("lw.f0", 6'b100011, 6'h0, 0, 0, S_FETCH, F_WAIT);
        step("lw.f1", 6'b100011, 6'h0, 0, 0, S_FETCH, F_WAIT);
        step("lw.f2", 6'b100011, 6'h0, 0, 1, S_FETCH, F_RDY);
        step("lw.d",  6'b100011, 6'h0, 0, 1, S_DEC, DEC);
        step("lw.a",  6'b100011, 6'h0, 0, 1, S_MA, C_IEX_ADD);
        step("lw.r0", 6'b100011, 6'h0, 0, 0, S_MRD, cv(0,1,1,0,0,0,0,0,0,0,0,4'd0,0,0));
        step("lw.r1", 6'b100011, 6'h0, 0, 0, S_MRD, cv(0,1,1,0,0,0,0,0,0,0,0,4'd0,0,0));
        step("lw.r2", 6'b100011, 6'h0, 0, 0, S_MRD, cv(0,1,1,0,0,0,0,0,0,0,0,4'd0,0,0));
        step("lw.r3", 6'b100011, 6'h0, 0, 1, S_MRD, cv(0,1,1,0,0,1,0,0,0,0,0,4'd0,0,0));
        step("lw.w",  6'b100011, 6'h0, 0, 1, S_MWB, cv(0,0,0,0,0,0,0,1,1,0,0,4'd0,0,0));
        chk("lw.cnt", 32'(instr_count), 32'd2);

        // beq not taken, then taken
        step("beq0.f", 6'b000100, 6'h0, 0, 1, S_FETCH, F_RDY);
        step("beq0.d", 6'b000100, 6'h0, 0, 1, S_DEC, DEC);
        step("beq0.b", 6'b000100, 6'h0, 0, 1, S_BR, cv(0,0,0,0,0,0,0,0,0,1,0,SUB,1,0));
        step("beq1.f", 6'b000100, 6'h0, 1, 1, S_FETCH, F_RDY);
        step("beq1.d", 6'b000100, 6'h0, 1, 1, S_DEC, DEC);
        step("beq1.b", 6'b000100, 6'h0, 1, 1, S_BR, cv(1,0,0,0,0,0,0,0,0,1,0,SUB,1,0));
        chk("beq.cnt", 32'(instr_count), 32'd4);

        // jal
        step("jal.f", 6'b000011, 6'h0, 0, 1, S_FETCH, F_RDY);
        step("jal.d", 6'b000011, 6'h0, 0, 1, S_DEC, DEC);
        step("jal.j", 6'b000011, 6'h0, 0, 1, S_JAL, cv(1,0,0,0,0,0,2,2,1,0,0,4'd0,2,0));
        chk("jal.cnt", 32'(instr_count), 32'd5);

        // sw with one write wait; count must not bump during the wait
        step("sw.f",  6'b101011, 6'h0, 0, 1, S_FETCH, F_RDY);
        step("sw.d",  6'b101011, 6'h0, 0, 1, S_DEC, DEC);
        step("sw.a",  6'b101011, 6'h0, 0, 1, S_MA, C_IEX_ADD);
        step("sw.m0", 6'b101011, 6'h0, 0, 0, S_MWR, cv(0,1,0,1,0,0,0,0,0,0,0,4'd0,0,0));
        chk("sw.cnt_wait", 32'(instr_count), 32'd5);
        step("sw.m1", 6'b101011, 6'h0, 0, 1, S_MWR, cv(0,1,0,1,0,0,0,0,0,0,0,4'd0,0,0));
        chk("sw.cnt", 32'(instr_count), 32'd6);

        // illegal opcode and illegal R-type func
        step("ill.f", 6'b111111, 6'h0, 1, 1, S_FETCH, F_RDY);
        step("ill.d", 6'b111111, 6'h0, 1, 1, S_DEC, DEC);
        step("ill.i", 6'b111111, 6'h0, 1, 1, S_ILL, cv(0,0,0,0,0,0,0,0,0,0,0,4'd0,0,1));
        step("ill.back", 6'b111111, 6'h0, 1, 0, S_FETCH, F_WAIT);
        step("illr.f", 6'h00, 6'b000111, 0, 1, S_FETCH, F_RDY);
        step("illr.d", 6'h00, 6'b000111, 0, 1, S_DEC, DEC);
        step("illr.i", 6'h00, 6'b000111, 0, 1, S_ILL, cv(0,0,0,0,0,0,0,0,0,0,0,4'd0,0,1));
        chk("ill.cnt", 32'(instr_count), 32'd6);

        // addi, ori
        step("addi.f", 6'b001000, 6'h0, 0, 1, S_FETCH, F_RDY);
        step("addi.d", 6'b001000, 6'h0, 0, 1, S_DEC, DEC);
        step("addi.x", 6'b001000, 6'h0, 0, 1, S_IEX, C_IEX_ADD);
        step("addi.w", 6'b001000, 6'h0, 0, 1, S_IWB, cv(0,0,0,0,0,0,0,0,1,0,0,4'd0,0,0));
        step("ori.f",  6'b001101, 6'h0, 0, 1, S_FETCH, F_RDY);
        step("ori.d",  6'b001101, 6'h0, 0, 1, S_DEC, DEC);
        step("ori.x",  6'b001101, 6'h0, 0, 1, S_IEX, cv(0,0,0,0,0,0,0,0,0,1,2,OR_,0,0));
        step("ori.w",  6'b001101, 6'h0, 0, 1, S_IWB, cv(0,0,0,0,0,0,0,0,1,0,0,4'd0,0,0));
        step("slti.f", 6'b001010, 6'h0, 0, 1, S_FETCH, F_RDY);
        step("slti.d", 6'b001010, 6'h0, 0, 1, S_DEC, DEC);
        step("slti.x", 6'b001010, 6'h0, 0, 1, S_IEX, cv(0,0,0,0,0,0,0,0,0,1,2,SLT,0,0));
        step("slti.w", 6'b001010, 6'h0, 0, 1, S_IWB, cv(0,0,0,0,0,0,0,0,1,0,0,4'd0,0,0));
        chk("itype.cnt", 32'(instr_count), 32'd9);

        // jr, j
        step("jr.f", 6'h00, 6'b001000, 0, 1, S_FETCH, F_RDY);
        step("jr.d", 6'h00, 6'b001000, 0, 1, S_DEC, DEC);
        step("jr.j", 6'h00, 6'b001000, 0, 1, S_JR, cv(1,0,0,0,0,0,0,0,0,0,0,4'd0,3,0));
        step("j.f",  6'b000010, 6'h0, 0, 1, S_FETCH, F_RDY);
        step("j.d",  6'b000010, 6'h0, 0, 1, S_DEC, DEC);
        step("j.j",  6'b000010, 6'h0, 0, 1, S_J, cv(1,0,0,0,0,0,0,0,0,0,0,4'd0,2,0));

        // sub, and, slt R-type ALU codes
        step("sub.f", 6'h00, 6'b100010, 0, 1, S_FETCH, F_RDY);
        step("sub.d", 6'h00, 6'b100010, 0, 1, S_DEC, DEC);
        step("sub.x", 6'h00, 6'b100010, 0, 1, S_REX, cv(0,0,0,0,0,0,0,0,0,1,0,SUB,0,0));
        step("sub.w", 6'h00, 6'b100010, 0, 1, S_RWB, C_RWB);
        step("and.f", 6'h00, 6'b100100, 0, 1, S_FETCH, F_RDY);
        step("and.d", 6'h00, 6'b100100, 0, 1, S_DEC, DEC);
        step("and.x", 6'h00, 6'b100100, 0, 1, S_REX, cv(0,0,0,0,0,0,0,0,0,1,0,AND_,0,0));
        step("and.w", 6'h00, 6'b100100, 0, 1, S_RWB, C_RWB);
        chk("misc.cnt", 32'(instr_count), 32'd13);

        // reset mid-R_EXEC (slt)
        step("rx.f", 6'h00, 6'b101010, 0, 1, S_FETCH, F_RDY);
        step("rx.d", 6'h00, 6'b101010, 0, 1, S_DEC, DEC);
        #1;
        chk("rx.x.state", 32'(state), 32'(S_REX));
        chk("rx.x.ctl", 32'(ctl), 32'(cv(0,0,0,0,0,0,0,0,0,1,0,SLT,0,0)));
        rst = 1'b1;
        #1;
        chk("rx.rst.state", 32'(state), 32'(S_FETCH));
        chk("rx.rst.ctl", 32'(ctl), 32'd0);
        chk("rx.rst.cnt", 32'(instr_count), 32'd0);
        @(posedge clk); #1;
        chk("rx.rst2.ctl", 32'(ctl), 32'd0);
        rst = 1'b0;
        step("rx.rel", 6'h00, 6'b101010, 0, 1, S_FETCH, F_RDY);
        step("rx.d2", 6'h00, 6'b101010, 0, 1, S_DEC, DEC);
        step("rx.x2", 6'h00, 6'b101010, 0, 1, S_REX, cv(0,0,0,0,0,0,0,0,0,1,0,SLT,0,0));
        step("rx.w2", 6'h00, 6'b101010, 0, 1, S_RWB, C_RWB);
        chk("rx.cnt", 32'(instr_count), 32'd1);

        // 16 more jumps: 17 retirements from reset wraps a 4-bit counter to 1
        for (int i = 0; i < 16; i++) begin
            step("wrap.f", 6'b000010, 6'h0, 0, 1, S_FETCH, F_RDY);
            step("wrap.d", 6'b000010, 6'h0, 0, 1, S_DEC, DEC);
            step("wrap.j", 6'b000010, 6'h0, 0, 1, S_J, cv(1,0,0,0,0,0,0,0,0,0,0,4'd0,2,0));
        end
        chk("wrap.cnt", 32'(instr_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
